// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axil_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } arb_state_t;

endpackage

// File: rtl/axil_rr_arbiter.sv
// Two-way requester pick, round-robin by default or fixed priority with AXIL_ARB_FIXED_PRIO_EN.
// Latency: combinational.
// Backpressure: none; the caller samples the pick only while idle.
module axil_rr_arbiter
    import axil_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    output logic               gnt_vld,
    output logic               gnt_idx
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        if (req[0] && req[1]) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
            gnt_idx = 1'b0;
`else
            gnt_idx = ~last_gnt;
`endif
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Serialises whole AXI4-Lite transactions from two requesters onto one slave (AXIL_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: one idle arbitration cycle per grant, then channels forwarded combinationally.
// Backpressure: non-granted requester sees all READY/VALID low; granted one sees the slave's handshakes directly.
module axil_arbiter_2to1
    import axil_arb_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDRESS-1:0]    S0_AWADDR,
    input  logic [ADDRESS-1:0]    S1_AWADDR,
    input  logic [ADDRESS-1:0]    S0_ARADDR,
    input  logic [ADDRESS-1:0]    S1_ARADDR,
    input  logic [DATA_WIDTH-1:0] S0_WDATA,
    input  logic [DATA_WIDTH-1:0] S1_WDATA,
    input  logic [3:0]            S0_WSTRB,
    input  logic [3:0]            S1_WSTRB,
    input  logic                  S0_AWVALID,
    input  logic                  S0_WVALID,
    input  logic                  S0_ARVALID,
    input  logic                  S0_BREADY,
    input  logic                  S0_RREADY,
    input  logic                  S1_AWVALID,
    input  logic                  S1_WVALID,
    input  logic                  S1_ARVALID,
    input  logic                  S1_BREADY,
    input  logic                  S1_RREADY,
    output logic                  S0_AWREADY,
    output logic                  S0_WREADY,
    output logic                  S0_ARREADY,
    output logic                  S0_BVALID,
    output logic                  S0_RVALID,
    output logic                  S1_AWREADY,
    output logic                  S1_WREADY,
    output logic                  S1_ARREADY,
    output logic                  S1_BVALID,
    output logic                  S1_RVALID,
    output logic [1:0]            S0_BRESP,
    output logic [1:0]            S1_BRESP,
    output logic [1:0]            S0_RRESP,
    output logic [1:0]            S1_RRESP,
    output logic [DATA_WIDTH-1:0] S0_RDATA,
    output logic [DATA_WIDTH-1:0] S1_RDATA,
    output logic [ADDRESS-1:0]    M_AWADDR,
    output logic [ADDRESS-1:0]    M_ARADDR,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_AWVALID,
    output logic                  M_WVALID,
    output logic                  M_ARVALID,
    output logic                  M_BREADY,
    output logic                  M_RREADY,
    input  logic                  M_AWREADY,
    input  logic                  M_WREADY,
    input  logic                  M_ARREADY,
    input  logic                  M_BVALID,
    input  logic                  M_RVALID,
    input  logic [1:0]            M_BRESP,
    input  logic [1:0]            M_RRESP,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    output logic                  ARB_GRANT,
    output logic                  ARB_BUSY
);

    arb_state_t state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [NUM_REQ-1:0] req;
    logic               pick_vld, pick_idx;

    assign req = {S1_AWVALID | S1_ARVALID, S0_AWVALID | S0_ARVALID};

    axil_rr_arbiter u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt_vld  (pick_vld),
        .gnt_idx  (pick_idx)
    );

    // Requester-side signals of the current grant
    logic [ADDRESS-1:0]    sel_awaddr, sel_araddr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [3:0]            sel_wstrb;
    logic                  sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;

    assign sel_awaddr  = gnt_q ? S1_AWADDR  : S0_AWADDR;
    assign sel_araddr  = gnt_q ? S1_ARADDR  : S0_ARADDR;
    assign sel_wdata   = gnt_q ? S1_WDATA   : S0_WDATA;
    assign sel_wstrb   = gnt_q ? S1_WSTRB   : S0_WSTRB;
    assign sel_awvalid = gnt_q ? S1_AWVALID : S0_AWVALID;
    assign sel_wvalid  = gnt_q ? S1_WVALID  : S0_WVALID;
    assign sel_arvalid = gnt_q ? S1_ARVALID : S0_ARVALID;
    assign sel_bready  = gnt_q ? S1_BREADY  : S0_BREADY;
    assign sel_rready  = gnt_q ? S1_RREADY  : S0_RREADY;

    logic                  fwd_awready, fwd_wready, fwd_arready, fwd_bvalid, fwd_rvalid;
    logic [1:0]            fwd_bresp, fwd_rresp;
    logic [DATA_WIDTH-1:0] fwd_rdata;

    always_comb begin
        M_AWADDR    = '0;
        M_ARADDR    = '0;
        M_WDATA     = '0;
        M_WSTRB     = '0;
        M_AWVALID   = 1'b0;
        M_WVALID    = 1'b0;
        M_ARVALID   = 1'b0;
        M_BREADY    = 1'b0;
        M_RREADY    = 1'b0;
        fwd_awready = 1'b0;
        fwd_wready  = 1'b0;
        fwd_arready = 1'b0;
        fwd_bvalid  = 1'b0;
        fwd_rvalid  = 1'b0;
        fwd_bresp   = AXI_RESP_OKAY;
        fwd_rresp   = AXI_RESP_OKAY;
        fwd_rdata   = '0;
        case (state_q)
            WR_ADDR: begin
                // Completed channels are masked so a lingering VALID cannot handshake twice
                M_AWADDR    = sel_awaddr;
                M_AWVALID   = sel_awvalid & ~aw_done_q;
                M_WDATA     = sel_wdata;
                M_WSTRB     = sel_wstrb;
                M_WVALID    = sel_wvalid & ~w_done_q;
                fwd_awready = M_AWREADY & ~aw_done_q;
                fwd_wready  = M_WREADY & ~w_done_q;
            end
            WR_RESP: begin
                M_BREADY   = sel_bready;
                fwd_bvalid = M_BVALID;
                fwd_bresp  = M_BRESP;
            end
            RD_ADDR: begin
                M_ARADDR    = sel_araddr;
                M_ARVALID   = sel_arvalid;
                fwd_arready = M_ARREADY;
            end
            RD_DATA: begin
                M_RREADY   = sel_rready;
                fwd_rvalid = M_RVALID;
                fwd_rresp  = M_RRESP;
                fwd_rdata  = M_RDATA;
            end
            default: ;
        endcase
    end

    assign S0_AWREADY = ~gnt_q & fwd_awready;
    assign S0_WREADY  = ~gnt_q & fwd_wready;
    assign S0_ARREADY = ~gnt_q & fwd_arready;
    assign S0_BVALID  = ~gnt_q & fwd_bvalid;
    assign S0_RVALID  = ~gnt_q & fwd_rvalid;
    assign S0_BRESP   = gnt_q ? AXI_RESP_OKAY : fwd_bresp;
    assign S0_RRESP   = gnt_q ? AXI_RESP_OKAY : fwd_rresp;
    assign S0_RDATA   = gnt_q ? '0 : fwd_rdata;

    assign S1_AWREADY = gnt_q & fwd_awready;
    assign S1_WREADY  = gnt_q & fwd_wready;
    assign S1_ARREADY = gnt_q & fwd_arready;
    assign S1_BVALID  = gnt_q & fwd_bvalid;
    assign S1_RVALID  = gnt_q & fwd_rvalid;
    assign S1_BRESP   = gnt_q ? fwd_bresp : AXI_RESP_OKAY;
    assign S1_RRESP   = gnt_q ? fwd_rresp : AXI_RESP_OKAY;
    assign S1_RDATA   = gnt_q ? fwd_rdata : '0;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d      = pick_idx;
                    last_gnt_d = pick_idx;
                    // Write wins over read within the same requester
                    state_d    = (pick_idx ? S1_AWVALID : S0_AWVALID) ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                aw_done_d = aw_done_q | (M_AWVALID & M_AWREADY);
                w_done_d  = w_done_q | (M_WVALID & M_WREADY);
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: if (M_BVALID && M_BREADY) state_d = IDLE;
            RD_ADDR: if (M_ARVALID && M_ARREADY) state_d = RD_DATA;
            RD_DATA: if (M_RVALID && M_RREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    assign ARB_GRANT = gnt_q;
    assign ARB_BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1 with a 32x32 register-file slave model and per-requester scoreboards.
// Latency: n/a. Backpressure: slave readies drop while a response is outstanding.
module tb_axil_arbiter_2to1;
    import axil_arb_pkg::*;

    localparam int TMO = 60;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic        ACLK, ARESETN;
    logic [31:0] s_awaddr [2], s_araddr [2], s_wdata [2], s_rdata [2];
    logic [3:0]  s_wstrb [2];
    logic        s_awvalid [2], s_wvalid [2], s_arvalid [2], s_bready [2], s_rready [2];
    logic        s_awready [2], s_wready [2], s_arready [2], s_bvalid [2], s_rvalid [2];
    logic [1:0]  s_bresp [2], s_rresp [2];
    logic [31:0] M_AWADDR, M_ARADDR, M_WDATA, M_RDATA;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY;
    logic        M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        ARB_GRANT, ARB_BUSY;

    axil_arbiter_2to1 dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S0_AWADDR(s_awaddr[0]), .S1_AWADDR(s_awaddr[1]),
        .S0_ARADDR(s_araddr[0]), .S1_ARADDR(s_araddr[1]),
        .S0_WDATA(s_wdata[0]), .S1_WDATA(s_wdata[1]),
        .S0_WSTRB(s_wstrb[0]), .S1_WSTRB(s_wstrb[1]),
        .S0_AWVALID(s_awvalid[0]), .S0_WVALID(s_wvalid[0]), .S0_ARVALID(s_arvalid[0]),
        .S0_BREADY(s_bready[0]), .S0_RREADY(s_rready[0]),
        .S1_AWVALID(s_awvalid[1]), .S1_WVALID(s_wvalid[1]), .S1_ARVALID(s_arvalid[1]),
        .S1_BREADY(s_bready[1]), .S1_RREADY(s_rready[1]),
        .S0_AWREADY(s_awready[0]), .S0_WREADY(s_wready[0]), .S0_ARREADY(s_arready[0]),
        .S0_BVALID(s_bvalid[0]), .S0_RVALID(s_rvalid[0]),
        .S1_AWREADY(s_awready[1]), .S1_WREADY(s_wready[1]), .S1_ARREADY(s_arready[1]),
        .S1_BVALID(s_bvalid[1]), .S1_RVALID(s_rvalid[1]),
        .S0_BRESP(s_bresp[0]), .S1_BRESP(s_bresp[1]),
        .S0_RRESP(s_rresp[0]), .S1_RRESP(s_rresp[1]),
        .S0_RDATA(s_rdata[0]), .S1_RDATA(s_rdata[1]),
        .M_AWADDR(M_AWADDR), .M_ARADDR(M_ARADDR), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_AWVALID(M_AWVALID), .M_WVALID(M_WVALID), .M_ARVALID(M_ARVALID),
        .M_BREADY(M_BREADY), .M_RREADY(M_RREADY),
        .M_AWREADY(M_AWREADY), .M_WREADY(M_WREADY), .M_ARREADY(M_ARREADY),
        .M_BVALID(M_BVALID), .M_RVALID(M_RVALID),
        .M_BRESP(M_BRESP), .M_RRESP(M_RRESP), .M_RDATA(M_RDATA),
        .ARB_GRANT(ARB_GRANT), .ARB_BUSY(ARB_BUSY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [1:0] resp_for(input logic [31:0] a);
        return (a[31:5] != '0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

    // Slave model: register file, one outstanding write and one outstanding read
    logic        sl_aw_got, sl_w_got, sl_bvalid, sl_rvalid;
    logic [31:0] sl_awaddr, sl_wdata, sl_rdata;
    logic [3:0]  sl_wstrb;
    logic [1:0]  sl_bresp, sl_rresp;
    logic [31:0] sl_mem [32];

    assign M_AWREADY = ~sl_aw_got;
    assign M_WREADY  = ~sl_w_got;
    assign M_ARREADY = ~sl_rvalid;
    assign M_BVALID  = sl_bvalid;
    assign M_BRESP   = sl_bresp;
    assign M_RVALID  = sl_rvalid;
    assign M_RRESP   = sl_rresp;
    assign M_RDATA   = sl_rdata;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0;
            sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0; sl_rdata <= '0;
            sl_bresp <= '0; sl_rresp <= '0;
        end else begin
            if (M_AWVALID && M_AWREADY) begin sl_aw_got <= 1'b1; sl_awaddr <= M_AWADDR; end
            if (M_WVALID && M_WREADY) begin sl_w_got <= 1'b1; sl_wdata <= M_WDATA; sl_wstrb <= M_WSTRB; end
            if (sl_aw_got && sl_w_got && !sl_bvalid) begin
                sl_bvalid <= 1'b1;
                sl_bresp  <= resp_for(sl_awaddr);
                if (resp_for(sl_awaddr) == AXI_RESP_OKAY)
                    for (int b = 0; b < 4; b++)
                        if (sl_wstrb[b]) sl_mem[sl_awaddr[4:0]][8*b +: 8] <= sl_wdata[8*b +: 8];
            end
            if (sl_bvalid && M_BREADY) begin sl_bvalid <= 1'b0; sl_aw_got <= 1'b0; sl_w_got <= 1'b0; end
            if (M_ARVALID && M_ARREADY) begin
                sl_rvalid <= 1'b1;
                sl_rresp  <= resp_for(M_ARADDR);
                sl_rdata  <= (resp_for(M_ARADDR) == AXI_RESP_OKAY) ? sl_mem[M_ARADDR[4:0]] : 32'h0;
            end
            if (sl_rvalid && M_RREADY) sl_rvalid <= 1'b0;
        end
    end

    logic any_out, s1_any;
    assign s1_any = |{s_awready[1], s_wready[1], s_arready[1], s_bvalid[1], s_rvalid[1],
                      s_bresp[1], s_rresp[1], s_rdata[1]};
    assign any_out = s1_any | (|{s_awready[0], s_wready[0], s_arready[0], s_bvalid[0], s_rvalid[0],
                      s_bresp[0], s_rresp[0], s_rdata[0], M_AWADDR, M_ARADDR, M_WDATA, M_WSTRB,
                      M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, ARB_GRANT, ARB_BUSY});

    int   vectors = 0, miscompares = 0;
    int   w_cnt = 0, s1_leak = 0, s1_ar_early = 0;
    bit   chk_s1_quiet = 0, chk_s1_ar = 0;
    logic aw_log [$];
    logic ar_log [$];
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    logic [31:0] shadow [32];

    always @(negedge ACLK) begin
        if (M_AWVALID && M_AWREADY) aw_log.push_back(ARB_GRANT);
        if (M_WVALID && M_WREADY) w_cnt++;
        if (M_ARVALID && M_ARREADY) ar_log.push_back(ARB_GRANT);
        if (chk_s1_quiet && s1_any) s1_leak++;
        if (chk_s1_ar && s_arready[1]) s1_ar_early++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push_exp(input int idx, input exp_t e);
        if (idx == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic pop_exp(input int idx, output exp_t e);
        e.resp = 2'bxx; e.data = 'x;
        if (idx == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
        if (idx == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    endtask

    task automatic wr(input int idx, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] strb, input int w_delay, input bit chk);
        exp_t e;
        int   cyc;
        bit   aw_pend, w_pend, aw_hs, w_hs;
        logic [1:0] got;
        e.resp = resp_for(a);
        e.data = '0;
        if (e.resp == AXI_RESP_OKAY)
            for (int b = 0; b < 4; b++) if (strb[b]) shadow[a[4:0]][8*b +: 8] = d[8*b +: 8];
        push_exp(idx, e);
        s_awaddr[idx] = a; s_wdata[idx] = d; s_wstrb[idx] = strb;
        s_bready[idx] = 1'b1;
        s_awvalid[idx] = 1'b1;
        s_wvalid[idx] = (w_delay == 0);
        if (chk) begin
            #1;
            check("idle_no_fwd", {M_AWVALID, M_WVALID, M_BREADY, ARB_BUSY}, 0);
        end
        aw_pend = 1; w_pend = 1; cyc = 0;
        while ((aw_pend || w_pend) && cyc < TMO) begin
            aw_hs = s_awvalid[idx] && s_awready[idx];
            w_hs  = s_wvalid[idx] && s_wready[idx];
            tick(); cyc++;
            if (aw_hs) begin s_awvalid[idx] = 1'b0; aw_pend = 0; end
            if (w_hs) begin s_wvalid[idx] = 1'b0; w_pend = 0; end
            if (w_pend && !s_wvalid[idx] && cyc >= w_delay) s_wvalid[idx] = 1'b1;
        end
        check("wr_addr_data_done", {aw_pend, w_pend}, 0);
        if (chk) check("exit_to_wr_resp", M_BREADY, 1);
        cyc = 0;
        while (!s_bvalid[idx] && cyc < TMO) begin tick(); cyc++; end
        check("bvalid", s_bvalid[idx], 1);
        got = s_bresp[idx];
        tick();
        s_bready[idx] = 1'b0;
        pop_exp(idx, e);
        check("bresp", got, e.resp);
    endtask

    task automatic rd(input int idx, input logic [31:0] a, input int rr_delay);
        exp_t e;
        int   cyc;
        logic [31:0] d0, got_d;
        logic [1:0]  got_r;
        e.resp = resp_for(a);
        e.data = shadow[a[4:0]];
        push_exp(idx, e);
        s_araddr[idx] = a;
        s_arvalid[idx] = 1'b1;
        cyc = 0;
        while (!s_arready[idx] && cyc < TMO) begin tick(); cyc++; end
        check("arready", s_arready[idx], 1);
        tick();
        s_arvalid[idx] = 1'b0;
        cyc = 0;
        while (!s_rvalid[idx] && cyc < TMO) begin tick(); cyc++; end
        check("rvalid", s_rvalid[idx], 1);
        d0 = s_rdata[idx];
        for (int k = 0; k < rr_delay; k++) begin
            check("rr_hold_mrready", M_RREADY, 0);
            check("rr_hold_mrvalid", M_RVALID, 1);
            check("rr_hold_rdata", M_RDATA, d0);
            check("rr_hold_grant", ARB_GRANT, idx);
            check("rr_other_wait", {s_awready[1-idx], s_wready[1-idx], s_arready[1-idx]}, 0);
            tick();
        end
        s_rready[idx] = 1'b1;
        got_d = s_rdata[idx];
        got_r = s_rresp[idx];
        tick();
        s_rready[idx] = 1'b0;
        if (idx == 0) chk_s1_ar = 0;
        pop_exp(idx, e);
        check("rdata", got_d, e.data);
        check("rresp", got_r, e.resp);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        tick();
    endtask

    initial begin
        ARESETN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_araddr[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
            s_awvalid[i] = 0; s_wvalid[i] = 0; s_arvalid[i] = 0; s_bready[i] = 0; s_rready[i] = 0;
        end
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outs", any_out, 0);
        ARESETN = 1'b1;
        tick();

        // Single write, AW and W together, S1 must stay silent
        aw_log.delete(); w_cnt = 0; s1_leak = 0; chk_s1_quiet = 1;
        wr(0, 32'd3, 32'hDEADBEEF, 4'hF, 0, 1);
        chk_s1_quiet = 0;
        check("t1_aw_count", aw_log.size(), 1);
        check("t1_w_count", w_cnt, 1);
        check("t1_s1_quiet", s1_leak, 0);

        // AW two cycles ahead of W
        aw_log.delete(); w_cnt = 0;
        wr(0, 32'd5, 32'h12345678, 4'hF, 2, 1);
        check("t3_aw_count", aw_log.size(), 1);
        check("t3_w_count", w_cnt, 1);
        wr(0, 32'h100, 32'hCAFEF00D, 4'hF, 0, 0);

        // Simultaneous reads straight after reset
        do_reset();
        ar_log.delete(); s1_ar_early = 0; chk_s1_ar = 1;
        fork
            rd(0, 32'd5, 0);
            rd(1, 32'd3, 0);
        join
        chk_s1_ar = 0;
        check("t2_ar_count", ar_log.size(), 2);
        if (ar_log.size() == 2) begin
            check("t2_grant_first", ar_log[0], 0);
            check("t2_grant_second", ar_log[1], 1);
        end
        check("t2_s1_arready_early", s1_ar_early, 0);

        // Both requesters streaming writes
        do_reset();
        aw_log.delete();
        fork
            for (int k = 0; k < 4; k++) wr(0, 32'd8 + k, 32'hA000_0000 + k, 4'hF, 0, 0);
            for (int k = 0; k < 4; k++) wr(1, 32'd16 + k, 32'hB000_0000 + k, 4'hF, 0, 0);
        join
        check("t4_aw_count", aw_log.size(), 8);
        for (int k = 0; k < 8 && k < aw_log.size(); k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
            check($sformatf("t4_grant_%0d", k), aw_log[k], (k >= 4));
`else
            check($sformatf("t4_grant_%0d", k), aw_log[k], k % 2);
`endif
        end
        rd(1, 32'd18, 0);
        rd(0, 32'd9, 0);

        // S0 stalls its read response while S1 waits
        fork
            rd(0, 32'd3, 3);
            begin
                tick(); tick();
                wr(1, 32'd20, 32'h5555AAAA, 4'hF, 0, 0);
            end
        join
        rd(0, 32'd20, 0);

        // Reset in the middle of a write address phase
        s_awaddr[0] = 32'd4; s_awvalid[0] = 1'b1;
        tick(); tick();
        check("t6_busy_before_rst", ARB_BUSY, 1);
        #2 ARESETN = 1'b0;
        #1 check("t6_async_outs", any_out, 0);
        s_awvalid[0] = 1'b0;
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        wr(1, 32'd9, 32'h0000_7788, 4'b0011, 0, 0);
        rd(1, 32'd9, 0);

        check("sb_empty0", exp_q0.size(), 0);
        check("sb_empty1", exp_q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
